// File: rtl/muldiv_pkg.sv
// Shared types, constants and op-classification helpers for the EX-stage
// multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam logic [4:0]      ITER_LAST    = 5'd31;
    localparam logic [XLEN-1:0] DIV0_QUOT    = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] OVF_DIVIDEND = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    function automatic logic is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_a(input md_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per
// enabled cycle; load on the accept edge.
module ex_muldiv_div_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   diff_s;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shifted_s = {rem_q, quot_q[XLEN-1]};
        diff_s    = shifted_s - {1'b0, dvsr_q};
    end

    // Remainder/quotient registers; a negative trial restores the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= 32'd0;
            rem_q  <= 32'd0;
            dvsr_q <= 32'd0;
        end else if (load) begin
            quot_q <= dividend;
            rem_q  <= 32'd0;
            dvsr_q <= divisor;
        end else if (step) begin
            rem_q  <= diff_s[XLEN] ? shifted_s[XLEN-1:0] : diff_s[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], ~diff_s[XLEN]};
        end else begin
            quot_q <= quot_q;
            rem_q  <= rem_q;
            dvsr_q <= dvsr_q;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the EX stage. Define EX_MULDIV_FAST_MUL_EN to
// replace the 32-cycle shift-add multiplier with a single-cycle multiply.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    input  logic            ex_advance,
    output logic            stall_req,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    import muldiv_pkg::*;

    md_state_e       state_q;
    md_op_e          op_s;
    md_op_e          op_q;
    logic [4:0]      cnt_q;
    logic [63:0]     acc_q;
    logic [63:0]     acc_d;
    logic [63:0]     mcand_q;
    logic [32:0]     mplier_q;
    logic            neg_quot_q;
    logic            neg_rem_q;
    logic            special_q;
    logic [XLEN-1:0] spec_res_q;
    logic            accept_s;
    logic            sa_s;
    logic            sb_s;
    logic [XLEN-1:0] a_abs_s;
    logic [XLEN-1:0] b_abs_s;
    logic            div0_s;
    logic            ovf_s;
    logic            div_load_s;
    logic [XLEN-1:0] quot_s;
    logic [XLEN-1:0] rem_s;
    logic [63:0]     prod_s;
    logic [XLEN-1:0] result_s;
`ifdef EX_MULDIV_FAST_MUL_EN
    logic [63:0]     fast_a_s;
    logic [63:0]     fast_b_s;
    logic [63:0]     fast_prod_s;
`endif

    // Accept decode, operand magnitudes and divide special-case detection
    always_comb begin
        op_s       = md_op_e'(op);
        accept_s   = (state_q == IDLE) && start && !flush;
        sa_s       = is_signed_a(op_s) && operand_a[XLEN-1];
        sb_s       = is_signed_b(op_s) && operand_b[XLEN-1];
        a_abs_s    = sa_s ? (32'd0 - operand_a) : operand_a;
        b_abs_s    = sb_s ? (32'd0 - operand_b) : operand_b;
        div0_s     = (operand_b == 32'd0);
        ovf_s      = is_signed_a(op_s) && (operand_a == OVF_DIVIDEND) && (operand_b == DIV0_QUOT);
        div_load_s = accept_s && is_div(op_s) && !div0_s && !ovf_s;
        acc_d      = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    end

`ifdef EX_MULDIV_FAST_MUL_EN
    // 33x33 signed multiply, evaluated modulo 2^64
    always_comb begin
        fast_a_s    = {{31{sa_s}}, sa_s, operand_a};
        fast_b_s    = {{31{sb_s}}, sb_s, operand_b};
        fast_prod_s = fast_a_s * fast_b_s;
    end
`endif

    ex_muldiv_div_core u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load_s),
        .step      (state_q == DIV),
        .dividend  (a_abs_s),
        .divisor   (b_abs_s),
        .quotient  (quot_s),
        .remainder (rem_s)
    );

    // Control FSM with operand latching and the shift-add multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_MUL;
            cnt_q      <= 5'd0;
            acc_q      <= 64'd0;
            mcand_q    <= 64'd0;
            mplier_q   <= 33'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        op_q  <= op_s;
                        cnt_q <= 5'd0;
                        if (is_div(op_s)) begin
                            neg_quot_q <= sa_s ^ sb_s;
                            neg_rem_q  <= sa_s;
                            special_q  <= div0_s || ovf_s;
                            if (div0_s) begin
                                spec_res_q <= (op_s == OP_REM || op_s == OP_REMU) ? operand_a : DIV0_QUOT;
                                state_q    <= DONE;
                            end else if (ovf_s) begin
                                spec_res_q <= (op_s == OP_REM) ? 32'd0 : OVF_DIVIDEND;
                                state_q    <= DONE;
                            end else begin
                                spec_res_q <= 32'd0;
                                state_q    <= DIV;
                            end
                        end else begin
`ifdef EX_MULDIV_FAST_MUL_EN
                            acc_q    <= fast_prod_s;
                            mcand_q  <= 64'd0;
                            mplier_q <= 33'd0;
                            state_q  <= DONE;
`else
                            acc_q    <= 64'd0;
                            mcand_q  <= {{32{sa_s}}, operand_a};
                            mplier_q <= {sb_s, operand_b};
                            state_q  <= MUL;
`endif
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MUL: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= {mcand_q[62:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[32:1]};
                        cnt_q    <= cnt_q + 5'd1;
                        state_q  <= (cnt_q == ITER_LAST) ? DONE : MUL;
                    end
                end
                DIV: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 5'd1;
                        state_q <= (cnt_q == ITER_LAST) ? DONE : DIV;
                    end
                end
                DONE: begin
                    state_q <= (flush || ex_advance) ? IDLE : DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Result select; the leftover multiplier bit is the sign of the 33-bit
    // multiplier, whose weight of -2^32 is applied here
    always_comb begin
        prod_s   = acc_q - (mplier_q[0] ? mcand_q : 64'd0);
        result_s = 32'd0;
        if (state_q == DONE) begin
            case (op_q)
                OP_MUL:                       result_s = prod_s[31:0];
                OP_MULH, OP_MULHSU, OP_MULHU: result_s = prod_s[63:32];
                OP_DIV, OP_DIVU:              result_s = special_q ? spec_res_q :
                                                         (neg_quot_q ? (32'd0 - quot_s) : quot_s);
                OP_REM, OP_REMU:              result_s = special_q ? spec_res_q :
                                                         (neg_rem_q ? (32'd0 - rem_s) : rem_s);
                default:                      result_s = 32'd0;
            endcase
        end else begin
            result_s = 32'd0;
        end
    end

    assign stall_req    = start && !flush && (state_q != DONE);
    assign result_valid = (state_q == DONE);
    assign result       = result_s;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv against an arithmetic reference.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        ex_advance;
    logic        stall_req;
    logic        result_valid;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .ex_advance   (ex_advance),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      pa;
        longint      pb;
        logic [63:0] p;
        sa = a;
        sb = b;
        case (o)
            3'd0: return a * b;
            3'd1: begin pa = longint'(sa); pb = longint'(sb); p = pa * pb; return p[63:32]; end
            3'd2: begin pa = longint'(sa); pb = longint'({32'd0, b}); p = pa * pb; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o < 3'd4) begin
`ifdef EX_MULDIV_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called just after a negedge: issue op, check timing, hold result, retire.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int          lat;
        exp        = ref_result(o, a, b);
        lat        = ref_latency(o, a, b);
        start      = 1'b1;
        op         = o;
        operand_a  = a;
        operand_b  = b;
        ex_advance = 1'b0;
        for (int c = 0; c < lat; c++) begin
            #1;
            check_val("busy_flags", {30'd0, stall_req, result_valid}, 32'd2);
            @(negedge clk);
            if (c == 0) begin
                operand_a = $urandom;
                operand_b = $urandom;
            end
        end
        ex_advance = (hold == 0);
        #1;
        check_val("done_flags", {30'd0, stall_req, result_valid}, 32'd1);
        check_val("result", result, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (h == hold - 1) ex_advance = 1'b1;
            #1;
            check_val("hold_flags", {30'd0, stall_req, result_valid}, 32'd1);
            check_val("hold_result", result, exp);
        end
        @(negedge clk);
        start      = 1'b0;
        ex_advance = 1'b0;
        #1;
        check_val("idle_flags", {30'd0, stall_req, result_valid}, 32'd0);
        check_val("idle_result", result, 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            #1;
            check_val(tag, {30'd0, stall_req, result_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        rst_n      = 1'b0;
        start      = 1'b0;
        op         = 3'd0;
        operand_a  = 32'd0;
        operand_b  = 32'd0;
        flush      = 1'b0;
        ex_advance = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_flags", {30'd0, stall_req, result_valid}, 32'd0);
        check_val("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd100, 32'd0, 0);
        run_op(3'd7, 32'd100, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(3'd5, 32'd50, 32'd7, 5);

        // flush part-way through a divide: no result may appear
        start     = 1'b1;
        op        = 3'd5;
        operand_a = 32'd50;
        operand_b = 32'd7;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_val("pre_flush_flags", {30'd0, stall_req, result_valid}, 32'd2);
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        check_val("flush_flags", {30'd0, stall_req, result_valid}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        expect_quiet("post_flush", 40);
        run_op(3'd7, 32'd50, 32'd7, 0);

        // flush together with start: the op is not accepted
        start     = 1'b1;
        flush     = 1'b1;
        op        = 3'd5;
        operand_a = 32'd5;
        operand_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        expect_quiet("flush_on_start", 5);

        // flush while holding a result discards it
        start     = 1'b1;
        op        = 3'd7;
        operand_a = 32'd9;
        operand_b = 32'd0;
        @(negedge clk);
        #1;
        check_val("div0_done", {31'd0, result_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        check_val("flush_done_flags", {30'd0, stall_req, result_valid}, 32'd0);
        expect_quiet("post_done_flush", 3);

        // asynchronous reset in the middle of a divide
        start     = 1'b1;
        op        = 3'd5;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        repeat (5) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("midreset_flags", {30'd0, stall_req, result_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("post_reset", 40);

        for (int i = 0; i < 60; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            run_op(ro, ra, rb, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
